pc_redirect_sequencer: RTL and testbench

- Program-counter owner for the fetch stage. Consumes jump/branch redirect requests and applies MIPS jump-target formation: J-type {PC+4[31:28], instr_index, 2'b00}, register jumps, and PC-relative branches.
- Honours the single architectural delay slot.
- Sits between decode, which issues redirect requests, and instruction memory, which is driven by pc.

---
 rtl/pc_redirect_sequencer.sv | 162 ++++++++++++++++
 tb/tb_pc_redirect_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_redirect_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_redirect_sequencer
// Description : Program-counter owner for the fetch stage. Advances pc
//               sequentially and applies redirects issued by decode. The
//               redirect kinds are:
//                 - J  : target is {pc+4[31:28], instr_index, 2'b00}
//                 - JR : target is a register value
//                 - BR : target is pc+4 plus a sign-extended word offset
//               A taken redirect reaches pc only after the single
//               architectural delay slot has been fetched.
// Ports       : clk, rst       - clock and synchronous active-high reset
//               stall          - freeze pc and FSM for this cycle
//               redir_valid    - a redirect request is present
//               redir_ready    - the sequencer accepts a request this cycle
//               redir_kind     - 00 J, 01 JR, 10 BR, 11 reserved
//               redir_index    - instr_index for J
//               redir_reg      - register target for JR
//               redir_off      - signed word offset for BR
//               pc, pc_plus4   - current fetch address and its successor
//               in_delay       - pc is the delay-slot instruction
//               addr_err       - one-cycle pulse after a rejected request
//               redir_count    - number of redirects taken (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module pc_redirect_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             redir_valid,
    output logic             redir_ready,
    input  logic [1:0]       redir_kind,
    input  logic [25:0]      redir_index,
    input  logic [31:0]      redir_reg,
    input  logic [15:0]      redir_off,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic             in_delay,
    output logic             addr_err,
    output logic [CNT_W-1:0] redir_count
);

    localparam logic [1:0] c_KIND_J  = 2'b00;
    localparam logic [1:0] c_KIND_JR = 2'b01;
    localparam logic [1:0] c_KIND_BR = 2'b10;

    typedef enum logic [0:0] {
        ST_SEQ   = 1'b0,
        ST_DELAY = 1'b1
    } state_t;

    state_t           r_state;
    logic [31:0]      r_pc;
    logic [31:0]      r_target;
    logic             r_addr_err;
    logic [CNT_W-1:0] r_count;

    state_t           w_state_nxt;
    logic [31:0]      w_pc_nxt;
    logic [31:0]      w_target_nxt;
    logic             w_addr_err_nxt;
    logic [CNT_W-1:0] w_count_nxt;

    logic [31:0]      w_pc_plus4;
    logic [31:0]      w_br_disp;
    logic [31:0]      w_target_calc;
    logic             w_reject;
    logic             w_accept;

    assign w_pc_plus4 = r_pc + 32'd4;

    // Word offset -> byte displacement, sign-extended to 32 bits.
    assign w_br_disp  = {{14{redir_off[15]}}, redir_off, 2'b00};

    assign redir_ready = (r_state == ST_SEQ) && !stall && !rst;
    assign w_accept    = redir_valid && redir_ready;

    // Target formation. The J region nibble comes from pc+4, so a jump
    // sitting in the last word of a 256 MB region lands in the next region.
    always_comb begin
        w_target_calc = 32'h0000_0000;
        w_reject      = 1'b0;
        case (redir_kind)
            c_KIND_J: begin
                w_target_calc = {w_pc_plus4[31:28], redir_index, 2'b00};
            end
            c_KIND_JR: begin
                w_target_calc = redir_reg;
                w_reject      = |redir_reg[1:0];
            end
            c_KIND_BR: begin
                w_target_calc = w_pc_plus4 + w_br_disp;
            end
            default: begin
                w_reject = 1'b1;
            end
        endcase
    end

    // Next-state logic. In SEQ the delay-slot instruction is always the
    // sequential successor, whether or not a redirect was accepted, so pc
    // advances by 4 in every unstalled SEQ cycle.
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_target_nxt   = r_target;
        w_count_nxt    = r_count;
        w_addr_err_nxt = 1'b0;
        case (r_state)
            ST_SEQ: begin
                if (!stall) begin
                    w_pc_nxt = w_pc_plus4;
                    if (w_accept) begin
                        if (w_reject) begin
                            w_addr_err_nxt = 1'b1;
                        end else begin
                            w_target_nxt = w_target_calc;
                            w_state_nxt  = ST_DELAY;
                        end
                    end
                end
            end
            ST_DELAY: begin
                if (!stall) begin
                    w_pc_nxt    = r_target;
                    w_state_nxt = ST_SEQ;
                    w_count_nxt = r_count + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_SEQ;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_SEQ;
            r_pc       <= RESET_PC;
            r_target   <= 32'h0000_0000;
            r_addr_err <= 1'b0;
            r_count    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_target   <= w_target_nxt;
            r_addr_err <= w_addr_err_nxt;
            r_count    <= w_count_nxt;
        end
    end

    assign pc          = r_pc;
    assign pc_plus4    = w_pc_plus4;
    assign in_delay    = (r_state == ST_DELAY);
    assign addr_err    = r_addr_err;
    assign redir_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_pc_redirect_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_redirect_sequencer
// Description : Directed bench for pc_redirect_sequencer. Three instances
//               with different reset pcs share the stimulus; the stimulus
//               process pushes the expected outputs of each cycle into a
//               scoreboard queue and a negedge monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_redirect_sequencer;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        valid_a;
    logic        valid_b;
    logic        valid_c;
    logic [1:0]  kind;
    logic [25:0] index;
    logic [31:0] rreg;
    logic [15:0] off;

    logic        rdy_a, rdy_b, rdy_c;
    logic [31:0] pc_a, pc_b, pc_c;
    logic [31:0] p4_a, p4_b, p4_c;
    logic        ind_a, ind_b, ind_c;
    logic        aerr_a, aerr_b, aerr_c;
    logic [15:0] cnt_a, cnt_b, cnt_c;

    typedef struct {
        int          id;
        int          sel;
        logic [31:0] pc;
        logic        ind;
        logic        aerr;
        logic [15:0] cnt;
        logic        rdy;
    } exp_t;

    exp_t sb[$];
    int   n_vec;
    int   n_err;
    int   next_id;

    pc_redirect_sequencer #(.RESET_PC(32'h0000_0000), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .stall(stall),
        .redir_valid(valid_a), .redir_ready(rdy_a), .redir_kind(kind),
        .redir_index(index), .redir_reg(rreg), .redir_off(off),
        .pc(pc_a), .pc_plus4(p4_a), .in_delay(ind_a), .addr_err(aerr_a),
        .redir_count(cnt_a)
    );

    pc_redirect_sequencer #(.RESET_PC(32'h0FFF_FFFC), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .stall(stall),
        .redir_valid(valid_b), .redir_ready(rdy_b), .redir_kind(kind),
        .redir_index(index), .redir_reg(rreg), .redir_off(off),
        .pc(pc_b), .pc_plus4(p4_b), .in_delay(ind_b), .addr_err(aerr_b),
        .redir_count(cnt_b)
    );

    pc_redirect_sequencer #(.RESET_PC(32'hFFFF_FFFC), .CNT_W(16)) dut_c (
        .clk(clk), .rst(rst), .stall(stall),
        .redir_valid(valid_c), .redir_ready(rdy_c), .redir_kind(kind),
        .redir_index(index), .redir_reg(rreg), .redir_off(off),
        .pc(pc_c), .pc_plus4(p4_c), .in_delay(ind_c), .addr_err(aerr_c),
        .redir_count(cnt_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every cycle, compare all expectations queued for it.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t        e;
            logic [31:0] a_pc, a_p4;
            logic        a_ind, a_aerr, a_rdy;
            logic [15:0] a_cnt;
            e = sb.pop_front();
            case (e.sel)
                1: begin a_pc = pc_b; a_p4 = p4_b; a_ind = ind_b; a_aerr = aerr_b; a_cnt = cnt_b; a_rdy = rdy_b; end
                2: begin a_pc = pc_c; a_p4 = p4_c; a_ind = ind_c; a_aerr = aerr_c; a_cnt = cnt_c; a_rdy = rdy_c; end
                default: begin a_pc = pc_a; a_p4 = p4_a; a_ind = ind_a; a_aerr = aerr_a; a_cnt = cnt_a; a_rdy = rdy_a; end
            endcase
            n_vec++;
            if (a_pc !== e.pc || a_p4 !== (e.pc + 32'd4) || a_ind !== e.ind ||
                a_aerr !== e.aerr || a_cnt !== e.cnt || a_rdy !== e.rdy) begin
                n_err++;
                $display("FAIL vec%0d dut%0d: got pc=%h pc4=%h dly=%b err=%b cnt=%0d rdy=%b, want pc=%h pc4=%h dly=%b err=%b cnt=%0d rdy=%b",
                         e.id, e.sel, a_pc, a_p4, a_ind, a_aerr, a_cnt, a_rdy,
                         e.pc, e.pc + 32'd4, e.ind, e.aerr, e.cnt, e.rdy);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic r, input logic s, input logic v,
                       input logic [1:0] k, input logic [25:0] idx,
                       input logic [31:0] rg, input logic [15:0] o);
        rst     = r;
        stall   = s;
        valid_a = v;
        kind    = k;
        index   = idx;
        rreg    = rg;
        off     = o;
    endtask

    task automatic idle();
        drv(1'b0, 1'b0, 1'b0, 2'b00, 26'h0, 32'h0, 16'h0);
    endtask

    task automatic chk(input int sel, input logic [31:0] p, input logic ind,
                       input logic aerr, input logic [15:0] cnt, input logic rdy);
        exp_t e;
        e.id   = next_id;
        e.sel  = sel;
        e.pc   = p;
        e.ind  = ind;
        e.aerr = aerr;
        e.cnt  = cnt;
        e.rdy  = rdy;
        next_id++;
        sb.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_vec   = 0;
        n_err   = 0;
        next_id = 0;
        valid_b = 1'b0;
        valid_c = 1'b0;
        drv(1'b1, 1'b0, 1'b0, 2'b00, 26'h0, 32'h0, 16'h0);

        // Reset held for two edges.
        tick();
        chk(0, 32'h0000_0000, 1'b0, 1'b0, 16'd0, 1'b0);
        chk(1, 32'h0FFF_FFFC, 1'b0, 1'b0, 16'd0, 1'b0);
        tick();

        // Release; instance b issues J index 0 from the region's last word.
        idle();
        valid_b = 1'b1;
        chk(0, 32'h0000_0000, 1'b0, 1'b0, 16'd0, 1'b1);
        chk(1, 32'h0FFF_FFFC, 1'b0, 1'b0, 16'd0, 1'b1);
        chk(2, 32'hFFFF_FFFC, 1'b0, 1'b0, 16'd0, 1'b1);
        tick();
        valid_b = 1'b0;
        chk(0, 32'h0000_0004, 1'b0, 1'b0, 16'd0, 1'b1);
        chk(1, 32'h1000_0000, 1'b1, 1'b0, 16'd0, 1'b0);
        chk(2, 32'h0000_0000, 1'b0, 1'b0, 16'd0, 1'b1);
        tick();
        chk(0, 32'h0000_0008, 1'b0, 1'b0, 16'd0, 1'b1);
        chk(1, 32'h1000_0000, 1'b0, 1'b0, 16'd1, 1'b1);
        tick();
        chk(0, 32'h0000_000C, 1'b0, 1'b0, 16'd0, 1'b1);
        tick();

        // J at 0x10, index 0x1234 -> delay 0x14, then 0x48D0.
        drv(1'b0, 1'b0, 1'b1, 2'b00, 26'h0001234, 32'h0, 16'h0);
        chk(0, 32'h0000_0010, 1'b0, 1'b0, 16'd0, 1'b1);
        tick();
        idle();
        chk(0, 32'h0000_0014, 1'b1, 1'b0, 16'd0, 1'b0);
        tick();
        chk(0, 32'h0000_48D0, 1'b0, 1'b0, 16'd1, 1'b1);
        tick();

        // JR to 0x100 to set up the branch test.
        drv(1'b0, 1'b0, 1'b1, 2'b01, 26'h0, 32'h0000_0100, 16'h0);
        chk(0, 32'h0000_48D4, 1'b0, 1'b0, 16'd1, 1'b1);
        tick();
        idle();
        chk(0, 32'h0000_48D8, 1'b1, 1'b0, 16'd1, 1'b0);
        tick();

        // BR off -2 words at 0x100 -> delay 0x104, target 0xFC, stalled 3 cycles.
        drv(1'b0, 1'b0, 1'b1, 2'b10, 26'h0, 32'h0, 16'hFFFE);
        chk(0, 32'h0000_0100, 1'b0, 1'b0, 16'd2, 1'b1);
        tick();
        for (int i = 0; i < 3; i++) begin
            drv(1'b0, 1'b1, 1'b0, 2'b00, 26'h0, 32'h0, 16'h0);
            chk(0, 32'h0000_0104, 1'b1, 1'b0, 16'd2, 1'b0);
            tick();
        end
        idle();
        chk(0, 32'h0000_0104, 1'b1, 1'b0, 16'd2, 1'b0);
        tick();
        chk(0, 32'h0000_00FC, 1'b0, 1'b0, 16'd3, 1'b1);
        tick();

        // Stall in SEQ holds pc and blocks acceptance.
        drv(1'b0, 1'b1, 1'b1, 2'b01, 26'h0, 32'h0000_0020, 16'h0);
        chk(0, 32'h0000_0100, 1'b0, 1'b0, 16'd3, 1'b0);
        tick();
        drv(1'b0, 1'b0, 1'b1, 2'b01, 26'h0, 32'h0000_0020, 16'h0);
        chk(0, 32'h0000_0100, 1'b0, 1'b0, 16'd3, 1'b1);
        tick();
        idle();
        chk(0, 32'h0000_0104, 1'b1, 1'b0, 16'd3, 1'b0);
        tick();

        // Misaligned JR at 0x20, then reserved kind at 0x24.
        drv(1'b0, 1'b0, 1'b1, 2'b01, 26'h0, 32'h0000_2002, 16'h0);
        chk(0, 32'h0000_0020, 1'b0, 1'b0, 16'd4, 1'b1);
        tick();
        drv(1'b0, 1'b0, 1'b1, 2'b11, 26'h0, 32'h0, 16'h0);
        chk(0, 32'h0000_0024, 1'b0, 1'b1, 16'd4, 1'b1);
        tick();
        idle();
        chk(0, 32'h0000_0028, 1'b0, 1'b1, 16'd4, 1'b1);
        tick();
        chk(0, 32'h0000_002C, 1'b0, 1'b0, 16'd4, 1'b1);
        tick();

        // J at 0x30, reset during the delay slot discards the target.
        drv(1'b0, 1'b0, 1'b1, 2'b00, 26'h0001234, 32'h0, 16'h0);
        chk(0, 32'h0000_0030, 1'b0, 1'b0, 16'd4, 1'b1);
        tick();
        drv(1'b1, 1'b0, 1'b0, 2'b00, 26'h0, 32'h0, 16'h0);
        chk(0, 32'h0000_0034, 1'b1, 1'b0, 16'd4, 1'b0);
        tick();
        idle();
        chk(0, 32'h0000_0000, 1'b0, 1'b0, 16'd0, 1'b1);
        tick();
        chk(0, 32'h0000_0004, 1'b0, 1'b0, 16'd0, 1'b1);
        tick();

        // BR offset 0 at 0x8: target equals pc+4, address 0xC fetched twice.
        drv(1'b0, 1'b0, 1'b1, 2'b10, 26'h0, 32'h0, 16'h0000);
        chk(0, 32'h0000_0008, 1'b0, 1'b0, 16'd0, 1'b1);
        tick();
        idle();
        chk(0, 32'h0000_000C, 1'b1, 1'b0, 16'd0, 1'b0);
        tick();
        chk(0, 32'h0000_000C, 1'b0, 1'b0, 16'd1, 1'b1);
        tick();
        chk(0, 32'h0000_0010, 1'b0, 1'b0, 16'd1, 1'b1);
        tick();

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
